// File: rtl/microwire_host.sv
// Microwire (93xx) serial EEPROM host controller.
// The CPU writes CMD/DATA through a four-register window. The block shifts the
// start bit, opcode, address and optional data out on CS/SK/DI. It captures read
// data from DO and polls DO for completion of a program or erase.
module microwire_host #(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned ADDR_BITS    = 6,
   parameter int unsigned POLL_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bus_sel,
   input  logic       bus_rw,
   input  logic [1:0] bus_addr,
   input  logic [7:0] bus_wdata,
   output logic [7:0] bus_rdata,
   output logic       ee_cs,
   output logic       ee_sk,
   output logic       ee_di,
   input  logic       ee_do,
   output logic       irq
);

   localparam int unsigned HdrBits   = 3 + ADDR_BITS;
   localparam int unsigned FrameBits = HdrBits + 16;
   // Bits sent after the start bit: opcode, address, data
   localparam int unsigned SregW     = FrameBits - 1;
   localparam int unsigned DivW      = $clog2(2 * CLK_DIV + 1);
   localparam int unsigned BitW      = $clog2(FrameBits + 1);
   localparam int unsigned PollW     = $clog2(POLL_TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StShiftOut,
      StShiftIn,
      StCsGap,
      StPoll,
      StDone
   } state_e;

   state_e             state_q;
   logic               cs_q, sk_q, di_q;
   logic [DivW-1:0]    div_q;
   logic [BitW-1:0]    bit_q;
   logic [BitW-1:0]    n_bits_q;
   logic [SregW-1:0]   sreg_q;
   logic               read_q;
   logic               poll_q;
   logic [PollW-1:0]   poll_cnt_q;
   logic [15:0]        data_q;
   logic               busy_q, done_q, err_busy_q, err_to_q;

   // Bus access decode
   logic                 bus_wr, bus_rd;
   logic                 cmd_wr, data_wr, status_rd;
   logic [1:0]           cmd_op;
   logic [1:0]           cmd_sp;
   logic [ADDR_BITS-1:0] cmd_addr;
   logic                 cmd_read, cmd_has_data, cmd_poll;

   // Decode bus strobes and the command byte being written
   always_comb begin
      bus_wr       = bus_sel & ~bus_rw;
      bus_rd       = bus_sel & bus_rw;
      cmd_wr       = bus_wr && (bus_addr == 2'd0);
      data_wr      = bus_wr && ((bus_addr == 2'd1) || (bus_addr == 2'd2));
      status_rd    = bus_rd && (bus_addr == 2'd3);
      cmd_op       = bus_wdata[7:6];
      cmd_addr     = bus_wdata[ADDR_BITS-1:0];
      cmd_sp       = bus_wdata[ADDR_BITS-1 -: 2];
      cmd_read     = (cmd_op == 2'b10);
      // WRITE, or WRAL among the special commands
      cmd_has_data = (cmd_op == 2'b01) || ((cmd_op == 2'b00) && (cmd_sp == 2'b01));
      // WRITE, ERASE, ERAL and WRAL all leave the EEPROM busy programming
      cmd_poll     = (cmd_op == 2'b01) || (cmd_op == 2'b11) ||
                     ((cmd_op == 2'b00) && ((cmd_sp == 2'b10) || (cmd_sp == 2'b01)));
   end

   // Transaction sequencer, serial pins and the register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cs_q       <= 1'b0;
         sk_q       <= 1'b0;
         di_q       <= 1'b0;
         div_q      <= '0;
         bit_q      <= '0;
         n_bits_q   <= '0;
         sreg_q     <= '0;
         read_q     <= 1'b0;
         poll_q     <= 1'b0;
         poll_cnt_q <= '0;
         data_q     <= 16'h0000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_busy_q <= 1'b0;
         err_to_q   <= 1'b0;
      end else begin
         // Clears come first so a set later in this block wins
         if (status_rd) begin
            done_q     <= 1'b0;
            err_busy_q <= 1'b0;
            err_to_q   <= 1'b0;
         end
         if ((cmd_wr || data_wr) && busy_q) begin
            err_busy_q <= 1'b1;
         end
         if (data_wr && !busy_q) begin
            if (bus_addr == 2'd1) data_q[7:0]  <= bus_wdata;
            else                  data_q[15:8] <= bus_wdata;
         end

         unique case (state_q)
            StIdle: begin
               if (cmd_wr) begin
                  state_q  <= StShiftOut;
                  cs_q     <= 1'b1;
                  sk_q     <= 1'b0;
                  di_q     <= 1'b1;
                  busy_q   <= 1'b1;
                  div_q    <= '0;
                  bit_q    <= '0;
                  sreg_q   <= {cmd_op, cmd_addr, (cmd_has_data ? data_q : 16'h0000)};
                  n_bits_q <= cmd_has_data ? BitW'(FrameBits) : BitW'(HdrBits);
                  read_q   <= cmd_read;
                  poll_q   <= cmd_poll;
               end
            end

            StShiftOut: begin
               if (div_q == DivW'(CLK_DIV - 1)) begin
                  div_q <= '0;
                  sk_q  <= ~sk_q;
                  // End of the SK-high half closes a bit period
                  if (sk_q) begin
                     if (bit_q == n_bits_q - BitW'(1)) begin
                        bit_q <= '0;
                        di_q  <= 1'b0;
                        if (read_q) begin
                           state_q <= StShiftIn;
                        end else begin
                           state_q <= StCsGap;
                           cs_q    <= 1'b0;
                        end
                     end else begin
                        bit_q  <= bit_q + BitW'(1);
                        di_q   <= sreg_q[SregW-1];
                        sreg_q <= {sreg_q[SregW-2:0], 1'b0};
                     end
                  end
               end else begin
                  div_q <= div_q + DivW'(1);
               end
            end

            StShiftIn: begin
               if (div_q == DivW'(CLK_DIV - 1)) begin
                  div_q <= '0;
                  sk_q  <= ~sk_q;
                  // Sample DO on the last clk of the SK-high half
                  if (sk_q) begin
                     data_q <= {data_q[14:0], ee_do};
                     if (bit_q == BitW'(15)) begin
                        bit_q   <= '0;
                        state_q <= StCsGap;
                        cs_q    <= 1'b0;
                     end else begin
                        bit_q <= bit_q + BitW'(1);
                     end
                  end
               end else begin
                  div_q <= div_q + DivW'(1);
               end
            end

            StCsGap: begin
               if (div_q == DivW'(2 * CLK_DIV - 1)) begin
                  div_q <= '0;
                  if (poll_q) begin
                     state_q    <= StPoll;
                     cs_q       <= 1'b1;
                     poll_cnt_q <= '0;
                  end else begin
                     state_q <= StDone;
                  end
               end else begin
                  div_q <= div_q + DivW'(1);
               end
            end

            StPoll: begin
               // DO high means the EEPROM has finished its internal cycle
               if (ee_do) begin
                  cs_q    <= 1'b0;
                  state_q <= StDone;
               end else if (poll_cnt_q == PollW'(POLL_TIMEOUT - 1)) begin
                  err_to_q <= 1'b1;
                  cs_q     <= 1'b0;
                  state_q  <= StDone;
               end else begin
                  poll_cnt_q <= poll_cnt_q + PollW'(1);
               end
            end

            StDone: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Register read mux; CMD is write-only and reads as zero
   always_comb begin
      bus_rdata = 8'h00;
      case (bus_addr)
         2'd0:    bus_rdata = 8'h00;
         2'd1:    bus_rdata = data_q[7:0];
         2'd2:    bus_rdata = data_q[15:8];
         default: bus_rdata = {4'h0, err_to_q, err_busy_q, done_q, busy_q};
      endcase
   end

   assign ee_cs = cs_q;
   assign ee_sk = sk_q;
   assign ee_di = di_q;
   assign irq   = done_q;

endmodule

// File: tb/tb_microwire_host.sv
// Self-checking bench for microwire_host with a behavioural EEPROM and pin monitor.
module tb_microwire_host;

   localparam int unsigned CD  = 2;
   localparam int unsigned AB  = 6;
   localparam int unsigned TO  = 40;
   localparam int unsigned HDR = 3 + AB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bus_sel = 1'b0;
   logic       bus_rw = 1'b0;
   logic [1:0] bus_addr = 2'd0;
   logic [7:0] bus_wdata = 8'h00;
   logic [7:0] bus_rdata;
   logic       ee_cs, ee_sk, ee_di;
   logic       ee_do = 1'b0;
   logic       irq;

   microwire_host #(
      .CLK_DIV      (CD),
      .ADDR_BITS    (AB),
      .POLL_TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_sel   (bus_sel),
      .bus_rw    (bus_rw),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .ee_cs     (ee_cs),
      .ee_sk     (ee_sk),
      .ee_di     (ee_di),
      .ee_do     (ee_do),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Pin monitor and EEPROM model state
   bit          di_bits[$];
   int          hi_runs[$];
   int          lo_runs[$];
   int          sk_rise = 0;
   int          session = 0;
   int          poll_seen = 0;
   int          run_len = 0;
   logic        prev_cs = 1'b0;
   logic        prev_sk = 1'b0;
   int          ee_mode = 0;      // 0 idle, 1 serve read, 2 program then go ready
   logic [15:0] ee_rdata = 16'h0;
   int          ee_wait = 0;

   logic [15:0] data_model = 16'h0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Watch pins away from the active edge; drive DO like a 93C46 would
   always @(negedge clk) begin
      if (ee_cs && !prev_sk && ee_sk) begin
         di_bits.push_back(ee_di);
         sk_rise++;
         if (ee_mode == 1 && session == 1 && sk_rise > HDR && sk_rise <= HDR + 16)
            ee_do = ee_rdata[HDR + 16 - sk_rise];
      end
      if (ee_cs != prev_cs) begin
         if (prev_cs) hi_runs.push_back(run_len);
         else if (hi_runs.size() > 0) lo_runs.push_back(run_len);
         run_len = 1;
         if (ee_cs) begin
            session++;
            sk_rise = 0;
            poll_seen = 0;
         end else begin
            ee_do = 1'b0;
         end
      end else begin
         run_len++;
      end
      if (ee_cs && ee_mode == 2 && session == 2) begin
         poll_seen++;
         if (poll_seen >= ee_wait) ee_do = 1'b1;
      end
      prev_cs = ee_cs;
      prev_sk = ee_sk;
   end

   task automatic clear_mon();
      di_bits.delete();
      hi_runs.delete();
      lo_runs.delete();
      session = 0;
      sk_rise = 0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      bus_sel = 1'b1; bus_rw = 1'b0; bus_addr = a; bus_wdata = d;
      @(negedge clk);
      bus_sel = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      bus_sel = 1'b1; bus_rw = 1'b1; bus_addr = a;
      #1 d = bus_rdata;
      @(negedge clk);
      bus_sel = 1'b0; bus_rw = 1'b0;
   endtask

   // kind: 0 READ, 1 WRITE, 2 ERASE, 3 EWEN, 4 EWDS, 5 ERAL, 6 WRAL
   task automatic do_txn(input int tn, input int kind, input int addr, input logic [15:0] wd,
                         input logic [15:0] rd, input int wait_n, input bit intrude,
                         input bit rd_at_done);
      int          op, a, cmd, nframe, prun, exp_busy, cnt, exp_n, exp_st;
      bit          has_data, polls, reads, timed_out;
      logic [63:0] exp_v, got_v;
      logic [7:0]  r;
      case (kind)
         0:       begin op = 2; a = addr % 64; end
         1:       begin op = 1; a = addr % 64; end
         2:       begin op = 3; a = addr % 64; end
         3:       begin op = 0; a = 48 + addr % 16; end
         4:       begin op = 0; a = addr % 16; end
         5:       begin op = 0; a = 32 + addr % 16; end
         default: begin op = 0; a = 16 + addr % 16; end
      endcase
      cmd      = op * 64 + a;
      has_data = (kind == 1 || kind == 6);
      polls    = (kind == 1 || kind == 2 || kind == 5 || kind == 6);
      reads    = (kind == 0);
      nframe   = HDR + (has_data ? 16 : 0);
      timed_out = polls && (wait_n > int'(TO));
      prun     = timed_out ? int'(TO) : wait_n;
      exp_busy = (nframe + (reads ? 16 : 0)) * 2 * CD + 2 * CD + (polls ? prun : 0) + 1;

      if (has_data) begin
         bus_write(2'd1, wd[7:0]);
         bus_write(2'd2, wd[15:8]);
         data_model = wd;
      end
      if (reads) data_model = rd;
      ee_mode  = reads ? 1 : (polls ? 2 : 0);
      ee_rdata = rd;
      ee_wait  = wait_n;
      clear_mon();
      bus_write(2'd0, 8'(cmd));

      cnt = 0;
      while (!irq && cnt < 2000) begin
         if (intrude && cnt == 5) begin
            bus_sel = 1'b1; bus_rw = 1'b0; bus_addr = 2'd0; bus_wdata = 8'($urandom);
         end else if (intrude && cnt == 6) begin
            bus_sel = 1'b1; bus_rw = 1'b0; bus_addr = 2'd1; bus_wdata = 8'($urandom);
         end else if (rd_at_done && cnt == exp_busy - 1) begin
            bus_sel = 1'b1; bus_rw = 1'b1; bus_addr = 2'd3;
            #1 check($sformatf("t%0d_status_at_done", tn), 64'(bus_rdata), 64'h01);
         end else begin
            bus_sel = 1'b0; bus_rw = 1'b0;
         end
         @(negedge clk);
         cnt++;
      end
      bus_sel = 1'b0; bus_rw = 1'b0;
      check($sformatf("t%0d_busy_cycles", tn), 64'(cnt), 64'(exp_busy));

      // Expected DI stream: start, opcode, address, data, then idle zeros while reading
      exp_v = '0; exp_n = 0;
      exp_v = {exp_v[62:0], 1'b1}; exp_n++;
      exp_v = {exp_v[62:0], 1'((op >> 1) & 1)}; exp_n++;
      exp_v = {exp_v[62:0], 1'(op & 1)}; exp_n++;
      for (int i = AB - 1; i >= 0; i--) begin
         exp_v = {exp_v[62:0], 1'((a >> i) & 1)}; exp_n++;
      end
      if (has_data) for (int i = 15; i >= 0; i--) begin
         exp_v = {exp_v[62:0], wd[i]}; exp_n++;
      end
      if (reads) for (int i = 0; i < 16; i++) begin
         exp_v = {exp_v[62:0], 1'b0}; exp_n++;
      end
      got_v = '0;
      foreach (di_bits[i]) got_v = {got_v[62:0], di_bits[i]};
      check($sformatf("t%0d_sk_pulses", tn), 64'(di_bits.size()), 64'(exp_n));
      check($sformatf("t%0d_di_stream", tn), got_v, exp_v);

      check($sformatf("t%0d_cs_sessions", tn), 64'(hi_runs.size()), 64'(polls ? 2 : 1));
      if (hi_runs.size() > 0)
         check($sformatf("t%0d_cs_frame_len", tn), 64'(hi_runs[0]),
               64'((nframe + (reads ? 16 : 0)) * 2 * CD));
      if (polls && hi_runs.size() > 1 && lo_runs.size() > 0) begin
         check($sformatf("t%0d_cs_gap", tn), 64'(lo_runs[0]), 64'(2 * CD));
         check($sformatf("t%0d_poll_len", tn), 64'(hi_runs[1]), 64'(prun));
      end

      check($sformatf("t%0d_irq", tn), 64'(irq), 64'h1);
      bus_read(2'd1, r);
      check($sformatf("t%0d_data_lo", tn), 64'(r), 64'(data_model[7:0]));
      bus_read(2'd2, r);
      check($sformatf("t%0d_data_hi", tn), 64'(r), 64'(data_model[15:8]));
      exp_st = 2 + (intrude ? 4 : 0) + (timed_out ? 8 : 0);
      bus_read(2'd3, r);
      check($sformatf("t%0d_status", tn), 64'(r), 64'(exp_st));
      bus_read(2'd3, r);
      check($sformatf("t%0d_status_clr", tn), 64'(r), 64'h00);
      check($sformatf("t%0d_irq_clr", tn), 64'(irq), 64'h0);
      ee_mode = 0;
   endtask

   initial begin
      logic [7:0] r;
      int         kind, w;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_cs", 64'(ee_cs), 64'h0);
      check("rst_sk", 64'(ee_sk), 64'h0);
      check("rst_di", 64'(ee_di), 64'h0);
      check("rst_irq", 64'(irq), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      bus_read(2'd3, r);
      check("rst_status", 64'(r), 64'h00);
      bus_read(2'd1, r);
      check("rst_data_lo", 64'(r), 64'h00);

      // Directed: READ 0x15 returning 0xBEEF
      do_txn(1, 0, 'h15, 16'h0, 16'hBEEF, 0, 1'b0, 1'b0);
      // Directed: WRITE 0x1234 to 0x0A, EEPROM ready after 30 clks
      do_txn(2, 1, 'h0A, 16'h1234, 16'h0, 30, 1'b0, 1'b0);
      // Directed: ERASE with DO stuck low times out
      do_txn(3, 2, 'h21, 16'h0, 16'h0, 100000, 1'b0, 1'b0);
      // Directed: READ with CMD and DATA_LO writes while busy
      do_txn(4, 0, 'h3C, 16'h0, 16'hA5C3, 0, 1'b1, 1'b0);
      // Directed: EWEN, STATUS read coinciding with done being set
      do_txn(5, 3, 'h00, 16'h0, 16'h0, 0, 1'b0, 1'b1);
      // Directed: WRAL and ERAL
      do_txn(6, 6, 'h07, 16'h8001, 16'h0, 5, 1'b0, 1'b0);
      do_txn(7, 5, 'h0F, 16'h0, 16'h0, 1, 1'b0, 1'b0);

      // Randomised transactions
      for (int t = 0; t < 20; t++) begin
         kind = int'($urandom_range(0, 6));
         w = ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(1, TO - 1));
         do_txn(10 + t, kind, int'($urandom_range(0, 63)), 16'($urandom), 16'($urandom), w,
                1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset in the middle of the frame
      clear_mon();
      bus_write(2'd0, 8'h95);
      repeat (10) @(negedge clk);
      check("midrst_cs_before", 64'(ee_cs), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cs", 64'(ee_cs), 64'h0);
      check("midrst_sk", 64'(ee_sk), 64'h0);
      check("midrst_di", 64'(ee_di), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_irq", 64'(irq), 64'h0);
      bus_read(2'd3, r);
      check("midrst_status", 64'(r), 64'h00);
      bus_read(2'd2, r);
      check("midrst_data_hi", 64'(r), 64'h00);
      data_model = 16'h0;

      // Controller still usable after the reset
      do_txn(50, 0, 'h2A, 16'h0, 16'h5AA5, 0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/microwire_host.md
Name: microwire_host

Overview:
- Bus-side host controller for a 93xx-series (Microwire) serial EEPROM.
- The CPU issues commands through a 4-register bus window. The block serialises start bit, opcode, address and optional write data onto CS/SK/DI.
- It collects 16-bit read data from DO and polls DO for write/erase completion.
- It sits between the system address decode (BA12/BA13, BR_W strobes) and the EEPROM pins. It is the upstream stage that drives and consumes the serial link.

Parameters:
- CLK_DIV, 4: clk cycles per SK half-period (≥1).
- ADDR_BITS, 6: EEPROM address width (6 = 93C46 x16).
- POLL_TIMEOUT, 65535: max clk cycles spent waiting for DO=1 after a program/erase.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bus_sel  in  1  register window selected, one-cycle strobe
- bus_rw  in  1  1 = read, 0 = write
- bus_addr  in  2  register index
- bus_wdata  in  8  write data
- bus_rdata  out  8  read data, combinational from registers
- ee_cs  out  1  chip select, active high
- ee_sk  out  1  serial clock
- ee_di  out  1  serial data to EEPROM
- ee_do  in  1  serial data from EEPROM; already synchronised upstream
- irq  out  1  high while STATUS.done=1

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values: ee_cs=0, ee_sk=0, ee_di=0, irq=0, DATA=0x0000, STATUS=0. Reset mid-transaction drops CS/SK/DI in the same instant, with no completion.
- Register map:
  - 0 CMD (write-only): [7:6] opcode, [ADDR_BITS-1:0] address.
  - 1 DATA_LO.
  - 2 DATA_HI.
  - 3 STATUS: bit0 busy, bit1 done, bit2 err_busy, bit3 err_timeout. Reads as 0 in bits [7:4].
- CMD register:
  - A write while idle starts a transaction.
  - A write while busy is ignored and sets err_busy.
  - A STATUS read clears done, err_busy and err_timeout on the read cycle. busy is not cleared.
- DATA registers:
  - Writes while busy are ignored and set err_busy.
  - DATA is loaded with read data at READ completion.
- Opcodes:
  - 10 READ.
  - 01 WRITE.
  - 11 ERASE.
  - 00 special, selected by address[ADDR_BITS-1:ADDR_BITS-2]:
    - 11 EWEN.
    - 00 EWDS.
    - 10 ERAL.
    - 01 WRAL.
  - WRITE and WRAL send 16 data bits (D15 first). All other opcodes send none.
- Frame sent on DI, MSB first: 1 (start), opcode[1:0], address. Length = 3+ADDR_BITS bits.
- SK timing:
  - Each bit period is CLK_DIV clocks with SK low, then CLK_DIV clocks with SK high.
  - DI changes only at the start of the SK-low half.
  - DO is sampled on the last clk of each SK-high half.
- States:
  - IDLE: on accepted CMD write, next cycle go to SHIFT_OUT with ee_cs=1, ee_di=start bit, busy=1.
  - SHIFT_OUT: on last bit → SHIFT_IN if READ, otherwise → CS_GAP.
  - SHIFT_IN: 16 SK cycles; DO shifted into DATA, first sample = D15. The EEPROM dummy 0 is not captured. Then → CS_GAP.
  - CS_GAP: ee_cs=0, ee_sk=0 for 2*CLK_DIV clocks.
    - READ/EWEN/EWDS → DONE.
    - WRITE/ERASE/ERAL/WRAL → POLL.
  - POLL:
    - ee_cs=1, SK held low.
    - DO=1 → deassert CS → DONE.
    - Counter reaching POLL_TIMEOUT → set err_timeout, deassert CS → DONE.
  - DONE: one cycle; set done, clear busy → IDLE.
- Simultaneous events: a STATUS read in the same cycle that DONE sets done leaves done=1; set wins over clear.
- Bus reads never stall. bus_rdata reflects register state in the same cycle.

Test Plan:
- Reset during SHIFT_OUT (CLK_DIV=4) → ee_cs/ee_sk/ee_di low before the next clk edge; STATUS=0x00 after release.
- CLK_DIV=2, CMD write 0x95 (READ addr 0x15), EEPROM model returns 0xBEEF:
  - ee_di sequence 1,1,0,0,1,0,1,0,1 across 9 SK pulses.
  - Exactly 16 further SK pulses.
  - busy high for 100 clks + CS_GAP(4) + DONE(1).
  - DATA_LO=0xEF, DATA_HI=0xBE, irq=1.
  - STATUS read returns 0x02, then 0x00.
- Write DATA=0x1234, CMD 0x4A (WRITE addr 0x0A); model holds DO low 50 clks:
  - DI shows the 9-bit header then 0001001000110100.
  - CS low 2*CLK_DIV clocks, then high until DO=1.
  - done set, err_timeout=0.
- POLL_TIMEOUT=20, ERASE with DO stuck low → CS drops after 20 POLL clocks; STATUS=0x0A.
- CMD write and DATA_LO write during a READ → transaction unaffected; err_busy set; DATA_LO holds read data afterwards.
- CMD 0x30 (EWEN) → frame 1,0,0,1,1,0,0,0,0; no poll; done after CS_GAP.
